// File: rtl/addr_queue.sv
// Tagged FIFO of outstanding request addresses with occupancy count, almost-full flag,
// selectable flush behaviour and a zero-latency granule lookup across live entries.
module addr_queue #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_THRESH = 12,
  parameter int MATCH_LSB    = 2,
  parameter int FLUSH_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wena,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rena,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      tag_reg;
  logic [DEPTH-1:0]      hit_vec;

  logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  empty_reg, empty_next;
  logic                  full_reg, full_next;
  logic                  afull_reg, afull_next;

  logic rd_fire;
  logic wr_fire;
  logic flush_all;

  assign rd_fire   = rena && !empty_reg;
  assign wr_fire   = wena && (!full_reg || rd_fire);
  assign flush_all = flush && (FLUSH_MODE == 1);

  // Flags and count follow the pointer movement; a simultaneous read+write leaves them alone.
  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    empty_next = empty_reg;
    full_next  = full_reg;
    if (rd_fire) rptr_next = rptr_reg + PTR_ONE;
    if (wr_fire) wptr_next = wptr_reg + PTR_ONE;
    if (wr_fire && !rd_fire) begin
      count_next = count_reg + CNT_ONE;
      empty_next = 1'b0;
      full_next  = ((wptr_reg + PTR_ONE) == rptr_reg);
    end else if (rd_fire && !wr_fire) begin
      count_next = count_reg - CNT_ONE;
      full_next  = 1'b0;
      empty_next = ((rptr_reg + PTR_ONE) == wptr_reg);
    end
    afull_next = (count_next >= AFULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
      afull_reg <= afull_next;
    end
  end

  // Data storage is never cleared; the tags say which contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset && !flush_all) mem[wptr_reg] <= wdata;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_WIDTH-1:0] offset;
      logic                  occupied;

      // Either flush mode kills tags; a write landing in the flush cycle stays killed.
      // On read+write to the same slot (full queue) the new entry's tag wins.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          tag_reg[gi] <= 1'b0;
        end else if (wr_fire && (wptr_reg == ADDR_WIDTH'(gi))) begin
          tag_reg[gi] <= 1'b1;
        end else if (rd_fire && (rptr_reg == ADDR_WIDTH'(gi))) begin
          tag_reg[gi] <= 1'b0;
        end
      end

      assign offset      = ADDR_WIDTH'(gi) - rptr_reg;
      assign occupied    = ({1'b0, offset} < count_reg);
      assign hit_vec[gi] = occupied && tag_reg[gi] &&
                           (mem[gi][DATA_WIDTH-1:MATCH_LSB] == lookup_addr[DATA_WIDTH-1:MATCH_LSB]);
    end
  endgenerate

  assign rdata       = mem[rptr_reg];
  assign valid       = tag_reg[rptr_reg];
  assign empty       = empty_reg;
  assign full        = full_reg;
  assign almost_full = afull_reg;
  assign count       = count_reg;
  assign lookup_hit  = |hit_vec;

endmodule

// File: tb/tb_addr_queue.sv
// Directed bench for addr_queue; one instance per flush mode, sharing all inputs.
module tb_addr_queue;

  logic        clk = 1'b0;
  logic        reset, flush, wena, rena;
  logic [31:0] wdata, lookup_addr;

  logic [31:0] rdata0, rdata1;
  logic        valid0, empty0, full0, afull0, hit0;
  logic        valid1, empty1, full1, afull1, hit1;
  logic [4:0]  count0, count1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_queue #(.FLUSH_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .wena(wena), .wdata(wdata), .rena(rena),
    .rdata(rdata0), .valid(valid0), .empty(empty0), .full(full0), .almost_full(afull0),
    .count(count0), .lookup_addr(lookup_addr), .lookup_hit(hit0)
  );

  addr_queue #(.FLUSH_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .wena(wena), .wdata(wdata), .rena(rena),
    .rdata(rdata1), .valid(valid1), .empty(empty1), .full(full1), .almost_full(afull1),
    .count(count1), .lookup_addr(lookup_addr), .lookup_hit(hit1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls, outputs sampled 1ns after the edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
    wena = w; wdata = d; rena = r; flush = f;
    @(posedge clk);
    #1;
    wena = 1'b0; rena = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  logic [31:0] q[$];
  logic        w, r, rd, wr;
  logic [31:0] d;

  initial begin
    reset = 1'b0; flush = 1'b0; wena = 1'b0; rena = 1'b0; wdata = '0; lookup_addr = '0;
    #2;

    // Reset state
    do_reset();
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_afull", 32'(afull0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_hit", 32'(hit0), 32'd0);
    $display("txn reset done");

    // Basic push x3, pop x3
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b0);
    chk("push3_count", 32'(count0), 32'd3);
    chk("push3_rdata", rdata0, 32'h100);
    chk("push3_valid", 32'(valid0), 32'd1);
    chk("push3_empty", 32'(empty0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("pop3_rdata", rdata0, 32'h100 + 32'(4 * i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      $display("txn pop %0d", i);
    end
    chk("pop3_empty", 32'(empty0), 32'd1);
    chk("pop3_count", 32'(count0), 32'd0);
    chk("pop3_valid", 32'(valid0), 32'd0);

    // Fill to 16, almost_full after the 12th push
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      if (i == 10) chk("afull_at11", 32'(afull0), 32'd0);
      if (i == 11) chk("afull_at12", 32'(afull0), 32'd1);
      if (i == 14) chk("full_at15", 32'(full0), 32'd0);
    end
    $display("txn fill 16");
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_count", 32'(count0), 32'd16);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("drop_count", 32'(count0), 32'd16);
    chk("drop_rdata", rdata0, 32'h1000);
    step(1'b1, 32'h5000, 1'b1, 1'b0);
    chk("fullrw_count", 32'(count0), 32'd16);
    chk("fullrw_full", 32'(full0), 32'd1);
    for (int i = 1; i < 17; i++) begin
      chk("drain_rdata", rdata0, (i == 16) ? 32'h5000 : 32'h1000 + 32'(4 * i));
      chk("drain_valid", 32'(valid0), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    $display("txn drain 16");
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_afull", 32'(afull0), 32'd0);

    // Flush with concurrent push
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    $display("txn flush+push");
    chk("fl0_count", 32'(count0), 32'd5);
    chk("fl0_valid", 32'(valid0), 32'd0);
    lookup_addr = 32'h200;
    #1;
    chk("fl0_hit", 32'(hit0), 32'd0);
    chk("fl1_count", 32'(count1), 32'd0);
    chk("fl1_empty", 32'(empty1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("fl0_pop_valid", 32'(valid0), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("fl0_drained", 32'(empty0), 32'd1);
    chk("fl1_stays_empty", 32'(count1), 32'd0);

    // Flush with push+pop
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    $display("txn flush+push+pop");
    chk("flrw1_empty", 32'(empty1), 32'd1);
    chk("flrw1_count", 32'(count1), 32'd0);
    chk("flrw1_full", 32'(full1), 32'd0);
    chk("flrw1_valid", 32'(valid1), 32'd0);
    chk("flrw0_count", 32'(count0), 32'd4);
    chk("flrw0_valid", 32'(valid0), 32'd0);

    // Lookup
    do_reset();
    step(1'b1, 32'h1000, 1'b0, 1'b0);
    step(1'b1, 32'h2004, 1'b0, 1'b0);
    lookup_addr = 32'h2006; #1;
    chk("lk_2006", 32'(hit0), 32'd1);
    lookup_addr = 32'h2008; #1;
    chk("lk_2008", 32'(hit0), 32'd0);
    lookup_addr = 32'h1003; #1;
    chk("lk_1003", 32'(hit0), 32'd1);
    lookup_addr = 32'h3000; wena = 1'b1; wdata = 32'h3000; #1;
    chk("lk_sameclk", 32'(hit0), 32'd0);
    step(1'b1, 32'h3000, 1'b0, 1'b0);
    chk("lk_afterwr", 32'(hit0), 32'd1);
    lookup_addr = 32'h2006;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lk_pop1", 32'(hit0), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lk_pop2", 32'(hit0), 32'd0);
    $display("txn lookup done");

    // Random push/pop against a FIFO model
    do_reset();
    q.delete();
    for (int c = 0; c < 40; c++) begin
      w = (c < 18) ? 1'b1 : ($urandom_range(0, 99) < 50);
      r = (c < 17) ? 1'b0 : ($urandom_range(0, 99) < 55);
      d = $urandom;
      if (q.size() > 0) begin
        chk("rnd_rdata", rdata0, q[0]);
        chk("rnd_valid", 32'(valid0), 32'd1);
      end else begin
        chk("rnd_empty", 32'(empty0), 32'd1);
      end
      rd = r && (q.size() > 0);
      wr = w && ((q.size() < 16) || rd);
      step(w, d, r, 1'b0);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
      chk("rnd_count0", 32'(count0), 32'(q.size()));
      chk("rnd_count1", 32'(count1), 32'(q.size()));
      chk("rnd_full", 32'(full0), 32'(q.size() == 16));
      $display("txn rnd %0d w=%0b r=%0b occ=%0d", c, w, r, q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
